// File: rtl/usr_cmd_sequencer.sv
// usr_cmd_sequencer: command sequencer feeding the 4-bit universal shift register.
// Queues {op, data, serial, count} commands in a small FIFO and plays each one onto
// the register's mode/serial/parallel pins for count+1 enabled cycles.
// Optional build macro: USR_SEQ_ABORT_EN adds the abort port (flush queue, return to idle).
module usr_cmd_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic                     cmd_serial,
    input  logic [CNT_W-1:0]         cmd_count,
`ifdef USR_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     usr_s1,
    output logic                     usr_s0,
    output logic                     usr_sl,
    output logic                     usr_sr,
    output logic [DATA_W-1:0]        usr_d,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
        logic              serial;
        logic [CNT_W-1:0]  count;
    } cmd_t;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    cmd_t             head;
    cmd_t             wr_entry;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic last;
    logic flush;

`ifdef USR_SEQ_ABORT_EN
    assign flush = abort;
`else
    assign flush = 1'b0;
`endif

    assign full       = (level == FULL_LVL);
    assign empty      = (level == '0);
    assign cmd_ready  = !full;
    assign fifo_level = level;
    assign head       = mem[rd_ptr];

    assign wr_entry.op     = cmd_op;
    assign wr_entry.data   = cmd_data;
    assign wr_entry.serial = cmd_serial;
    assign wr_entry.count  = cmd_count;

    // Final issue cycle of the current command: counter exhausted.
    assign last = (state == ISSUE) && (cnt == '0);

    // Push ignores ena; a full queue refuses even when a pop happens on the same edge.
    assign push = cmd_valid && !full && !flush;

    // Pop from IDLE, or back-to-back on the last issue cycle so commands chain without a bubble.
    assign pop  = ena && !flush && !empty && ((state == IDLE) || last);

    assign busy = (state == ISSUE) || !empty;

    // done marks the enabled final issue cycle; suppressed by reset or abort on that edge.
    assign done = rst_n && ena && !flush && last;

    // Command storage write; contents need no reset because level/pointers qualify them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Issue FSM with registered shift-register controls; everything holds while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            usr_s1 <= 1'b0;
            usr_s0 <= 1'b0;
            usr_sl <= 1'b0;
            usr_sr <= 1'b0;
            usr_d  <= '0;
        end else if (flush) begin
            // usr_d and the serial pins keep their values; only the mode returns to HOLD.
            state  <= IDLE;
            cnt    <= '0;
            usr_s1 <= 1'b0;
            usr_s0 <= 1'b0;
        end else if (ena) begin
            if (pop) begin
                state            <= ISSUE;
                cnt              <= head.count;
                {usr_s1, usr_s0} <= head.op;
                usr_sr           <= (head.op == OP_SHR) ? head.serial : 1'b0;
                usr_sl           <= (head.op == OP_SHL) ? head.serial : 1'b0;
                if (head.op == OP_LOAD) begin
                    usr_d <= head.data;
                end
            end else if (state == ISSUE) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    state  <= IDLE;
                    usr_s1 <= 1'b0;
                    usr_s0 <= 1'b0;
                end
            end
        end
    end

endmodule
